key_debounce: RTL and testbench



---
 rtl/key_debounce_pkg.sv | 17 +
 rtl/key_debounce_ch.sv | 152 +++++++++++++++
 rtl/key_debounce.sv | 49 ++++
 tb/tb_key_debounce.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/key_debounce_pkg.sv
// Shared types and 50 MHz default timing constants for the push-button debouncer.
// State encoding is a plain 2-bit vector so older consumers can keep comparing raw codes.
package key_debounce_pkg;

    typedef logic [1:0] key_state_t;

    localparam key_state_t ST_IDLE        = 2'd0;
    localparam key_state_t ST_PRESS_CHK   = 2'd1;
    localparam key_state_t ST_HELD        = 2'd2;
    localparam key_state_t ST_RELEASE_CHK = 2'd3;

    // 20 ms debounce, 500 ms first repeat, 100 ms repeat rate at 50 MHz
    localparam int unsigned KD_DEBOUNCE_50M      = 1000000;
    localparam int unsigned KD_REPEAT_DELAY_50M  = 25000000;
    localparam int unsigned KD_REPEAT_PERIOD_50M = 5000000;

endpackage

// File: rtl/key_debounce_ch.sv
// Purpose: one key channel: 2-flop synchronizer, 4-state debounce FSM, optional auto-repeat (KEY_AUTOREPEAT_EN).
// Latency: press/release strobe in the cycle after edge e0 + DEBOUNCE_CYCLES + 2 (e0 = first edge sampling the new level).
// Backpressure: none; strobes are single-cycle and fire-and-forget.
module key_debounce_ch
    import key_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = KD_DEBOUNCE_50M
`ifdef KEY_AUTOREPEAT_EN
    ,
    parameter int unsigned REPEAT_DELAY    = KD_REPEAT_DELAY_50M,
    parameter int unsigned REPEAT_PERIOD   = KD_REPEAT_PERIOD_50M
`endif
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic key_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    logic          sync_q1;
    logic          sync_q2;
    logic          pressed;
    key_state_t    state_q;
    key_state_t    state_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          level_d;
    logic          press_d;
    logic          release_d;

    // Synchronizer resets to "released" so a key held through reset is seen as a fresh press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q1 <= 1'b1;
            sync_q2 <= 1'b1;
        end else begin
            sync_q1 <= key_n;
            sync_q2 <= sync_q1;
        end
    end

    assign pressed = ~sync_q2;

`ifdef KEY_AUTOREPEAT_EN
    localparam int RW = $clog2(REPEAT_DELAY + 1);
    localparam logic [RW-1:0] RPT_LAST   = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RPT_RELOAD = RW'(REPEAT_DELAY - REPEAT_PERIOD);

    logic [RW-1:0] rpt_q;
    logic [RW-1:0] rpt_d;
    logic          rpt_fire;

    // Reloading to DELAY-PERIOD makes every later repeat land PERIOD cycles apart
    always_comb begin
        rpt_d    = '0;
        rpt_fire = 1'b0;
        if (state_q == ST_HELD && pressed) begin
            if (rpt_q == RPT_LAST) begin
                rpt_fire = 1'b1;
                rpt_d    = RPT_RELOAD;
            end else begin
                rpt_d    = rpt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rpt_q <= '0;
        else        rpt_q <= rpt_d;
    end
`else
    logic rpt_fire;
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        level_d   = key_level;
        press_d   = 1'b0;
        release_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (pressed) begin
                    state_d = ST_PRESS_CHK;
                    cnt_d   = CW'(1);
                end
            end
            ST_PRESS_CHK: begin
                if (!pressed) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = ST_HELD;
                    cnt_d   = '0;
                    press_d = 1'b1;
                    level_d = 1'b1;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            ST_HELD: begin
                if (!pressed) begin
                    state_d = ST_RELEASE_CHK;
                    cnt_d   = CW'(1);
                end else begin
                    press_d = rpt_fire;
                end
            end
            ST_RELEASE_CHK: begin
                if (pressed) begin
                    state_d   = ST_HELD;
                    cnt_d     = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    cnt_d     = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                level_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            key_level     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            key_level     <= level_d;
            press_pulse   <= press_d;
            release_pulse <= release_d;
        end
    end

endmodule

// File: rtl/key_debounce.sv
// Purpose: debounce and edge-detect N_KEYS active-low push-buttons; auto-repeat when KEY_AUTOREPEAT_EN is defined.
// Latency: press/release strobe in the cycle after edge e0 + DEBOUNCE_CYCLES + 2 (e0 = first edge sampling the new level).
// Backpressure: none; strobes are single-cycle and fire-and-forget, channels fully independent.
module key_debounce
    import key_debounce_pkg::*;
#(
    parameter int          N_KEYS          = 3,
    parameter int unsigned DEBOUNCE_CYCLES = KD_DEBOUNCE_50M,
    parameter int unsigned REPEAT_DELAY    = KD_REPEAT_DELAY_50M,
    parameter int unsigned REPEAT_PERIOD   = KD_REPEAT_PERIOD_50M
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [N_KEYS-1:0] key_n,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] press_pulse,
    output logic [N_KEYS-1:0] release_pulse
);

    if (DEBOUNCE_CYCLES < 2 || REPEAT_DELAY == 0 || REPEAT_PERIOD == 0) begin : g_bad_cfg
        $error("key_debounce: DEBOUNCE_CYCLES must be >= 2 and repeat timings non-zero");
    end

`ifdef KEY_AUTOREPEAT_EN
    // Repeat reload arithmetic needs the first gap to be at least one period
    if (REPEAT_DELAY < REPEAT_PERIOD) begin : g_bad_rpt
        $error("key_debounce: REPEAT_DELAY must be >= REPEAT_PERIOD");
    end
`endif

    for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
        key_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
`ifdef KEY_AUTOREPEAT_EN
            ,
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
        ) u_ch (
            .clk           (clk),
            .rst_n         (rst_n),
            .key_n         (key_n[i]),
            .key_level     (key_level[i]),
            .press_pulse   (press_pulse[i]),
            .release_pulse (release_pulse[i])
        );
    end

endmodule

// File: tb/tb_key_debounce.sv
// Self-checking bench for key_debounce: expected strobes queued at stimulus time, popped when the DUT fires.
// Small debounce/repeat constants keep every scenario to a few dozen cycles.
module tb_key_debounce;

    localparam int NK  = 3;
    localparam int DB  = 8;
    localparam int RD  = 20;
    localparam int RP  = 5;
    localparam int LAT = DB + 3;  // drive at negedge with cyc=c -> strobe seen at negedge with cyc=c+LAT

    logic          clk = 1'b0;
    logic          rst_n;
    logic [NK-1:0] key_n;
    logic [NK-1:0] key_level;
    logic [NK-1:0] press_pulse;
    logic [NK-1:0] release_pulse;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          cyc;
        logic [NK-1:0] prs;
        logic [NK-1:0] rel;
    } evt_t;

    evt_t sb_q[$];

    key_debounce #(
        .N_KEYS          (NK),
        .DEBOUNCE_CYCLES (DB),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .key_n         (key_n),
        .key_level     (key_level),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic expect_evt(input int dly, input logic [NK-1:0] p, input logic [NK-1:0] r);
        evt_t e;
        e.cyc = cyc + dly;
        e.prs = p;
        e.rel = r;
        sb_q.push_back(e);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Every strobe must match the oldest queued expectation in cycle and bit pattern
    always @(negedge clk) begin
        evt_t e;
        if (rst_n === 1'b1 && (press_pulse | release_pulse) !== '0) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_evt", {26'd0, press_pulse, release_pulse}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("evt_cyc", cyc, e.cyc);
                chk("evt_press", press_pulse, e.prs);
                chk("evt_release", release_pulse, e.rel);
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        key_n = '1;
        wait_cyc(3);
        chk("rst_level", key_level, 0);
        chk("rst_press", press_pulse, 0);
        chk("rst_release", release_pulse, 0);
        rst_n = 1'b1;
        wait_cyc(2);

        // Clean press on key 0
        key_n[0] = 1'b0;
        expect_evt(LAT, 3'b001, 3'b000);
        wait_cyc(14);
        chk("clean_level", key_level, 3'b001);

        // Release glitch of 4 cycles while held
        key_n[0] = 1'b1;
        wait_cyc(3);
        chk("glitch_mid_level", key_level, 3'b001);
        wait_cyc(1);
        key_n[0] = 1'b0;
        wait_cyc(8);
        chk("glitch_level", key_level, 3'b001);
        key_n[0] = 1'b1;
        expect_evt(LAT, 3'b000, 3'b001);
        wait_cyc(15);
        chk("rel0_level", key_level, 3'b000);

        // Bounce on key 1: low 3 / high 2 / then stable low
        key_n[1] = 1'b0;
        wait_cyc(3);
        key_n[1] = 1'b1;
        wait_cyc(2);
        key_n[1] = 1'b0;
        expect_evt(LAT, 3'b010, 3'b000);
        wait_cyc(14);
        chk("bounce_level", key_level, 3'b010);
        key_n[1] = 1'b1;
        expect_evt(LAT, 3'b000, 3'b010);
        wait_cyc(15);

        // All keys on the same edge
        key_n = 3'b000;
        expect_evt(LAT, 3'b111, 3'b000);
        wait_cyc(14);
        chk("all_level", key_level, 3'b111);
        key_n = 3'b111;
        expect_evt(LAT, 3'b000, 3'b111);
        wait_cyc(15);
        chk("all_rel_level", key_level, 3'b000);

        // Reset while key 0 held and key 2 mid-debounce (counter at 5)
        key_n[0] = 1'b0;
        expect_evt(LAT, 3'b001, 3'b000);
        wait_cyc(14);
        key_n[2] = 1'b0;
        wait_cyc(7);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_level", key_level, 0);
        chk("rst_mid_press", press_pulse, 0);
        chk("rst_mid_release", release_pulse, 0);
        wait_cyc(3);
        rst_n = 1'b1;
        expect_evt(LAT, 3'b101, 3'b000);
        wait_cyc(14);
        chk("post_rst_level", key_level, 3'b101);
        key_n = 3'b111;
        expect_evt(LAT, 3'b000, 3'b101);
        wait_cyc(15);

        // Long hold on key 1: repeats only when auto-repeat is built in
        key_n[1] = 1'b0;
        expect_evt(LAT, 3'b010, 3'b000);
`ifdef KEY_AUTOREPEAT_EN
        for (int k = 0; k < 9; k++) expect_evt(LAT + RD + RP * k, 3'b010, 3'b000);
`endif
        wait_cyc(LAT + 62);
        chk("hold_level", key_level, 3'b010);
        key_n[1] = 1'b1;
        expect_evt(LAT, 3'b000, 3'b010);
        wait_cyc(20);
        chk("final_level", key_level, 3'b000);

        wait_cyc(5);
        chk("sb_empty", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
